gate_sweep_controller: RTL

Self-checking stimulus sequencer for a 2-input combinational gate, such as the `out = a | b` OR datapath. On `start` it drives the gate inputs through all four combinations (00, 01, 10, 11), holding each for a programmable dwell time. At the end of each dwell it samples the gate output and compares it against a parameterised expected truth table. It then reports per-vector failures, an error count, and pass/done status, replacing hand-written `#10` stimulus with a clocked, reusable checker.

---
 rtl/gate_sweep_controller.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/gate_sweep_controller.sv
`default_nettype none
// ============================================================================
// Module      : gate_sweep_controller
// Description : Clocked stimulus sequencer and checker for a 2-input
//               combinational gate. On start it walks {drv_a,drv_b} through
//               00, 01, 10, 11, holding each vector for DWELL cycles, samples
//               dut_out on the last edge of each dwell and compares it with
//               EXPECT_TT[{a,b}]. It reports a per-vector fail mask, an error
//               count and pass/done status.
//
// Ports       : clk        system clock, rising edge
//               rst        asynchronous active-high reset
//               start      begin a sweep (honoured in IDLE/DONE only)
//               abort      terminate a running sweep
//               dut_out    output of the gate under control
//               drv_a      gate input a (registered)
//               drv_b      gate input b (registered)
//               busy       sweep in progress
//               done       sweep completed, sticky until next start/reset
//               pass       valid with done, equals (fail_mask == 0)
//               err_count  number of mismatching vectors, 0..4
//               fail_mask  bit k set when vector k mismatched
//
// Revision    : 1.0 - initial release
// ============================================================================
module gate_sweep_controller #(
    parameter int           DWELL     = 10,
    parameter logic [3:0]   EXPECT_TT = 4'b1110
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic        dut_out,
    output logic        drv_a,
    output logic        drv_b,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [2:0]  err_count,
    output logic [3:0]  fail_mask
);

    localparam logic [7:0] c_DWELL_LAST = 8'(DWELL - 1);
    localparam logic [2:0] c_ERR_MAX    = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t      r_state;
    logic [1:0]  r_vec;
    logic [7:0]  r_dwell;

    logic        w_launch;
    logic        w_run;
    logic [1:0]  w_cur_vec;
    logic [7:0]  w_cur_dwell;
    logic [3:0]  w_mask_base;
    logic [2:0]  w_err_base;
    logic        w_sample;
    logic        w_miss;
    logic [3:0]  w_mask_next;
    logic [2:0]  w_err_next;

    // Vector 00 is already on the pins while idle or done, so the start edge
    // itself counts as the first dwell cycle of vector 0. The launch edge is
    // therefore treated as a DRIVE tick with vec=0, dwell=0 and cleared
    // results; this makes vector k's sample edge land on start+(k+1)*DWELL-1
    // and gives a busy window of exactly 4*DWELL-1 cycles.
    always_comb begin
        w_launch    = (r_state != S_DRIVE) && start && !abort;
        w_run       = ((r_state == S_DRIVE) && !abort) || w_launch;
        w_cur_vec   = w_launch ? 2'd0 : r_vec;
        w_cur_dwell = w_launch ? 8'd0 : r_dwell;
        w_mask_base = w_launch ? 4'b0000 : fail_mask;
        w_err_base  = w_launch ? 3'd0 : err_count;
        w_sample    = (w_cur_dwell == c_DWELL_LAST);
        w_miss      = (dut_out != EXPECT_TT[w_cur_vec]);
        w_mask_next = w_mask_base;
        w_err_next  = w_err_base;
        if (w_sample && w_miss) begin
            w_mask_next = w_mask_base | (4'b0001 << w_cur_vec);
            if (w_err_base < c_ERR_MAX) begin
                w_err_next = w_err_base + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_vec     <= 2'd0;
            r_dwell   <= 8'd0;
            drv_a     <= 1'b0;
            drv_b     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= 3'd0;
            fail_mask <= 4'b0000;
        end else if (w_run) begin
            fail_mask <= w_mask_next;
            err_count <= w_err_next;
            if (w_sample && (w_cur_vec == 2'd3)) begin
                r_state <= S_DONE;
                r_vec   <= 2'd0;
                r_dwell <= 8'd0;
                drv_a   <= 1'b0;
                drv_b   <= 1'b0;
                busy    <= 1'b0;
                done    <= 1'b1;
                pass    <= (w_mask_next == 4'b0000);
            end else if (w_sample) begin
                r_state <= S_DRIVE;
                r_vec   <= w_cur_vec + 2'd1;
                r_dwell <= 8'd0;
                {drv_a, drv_b} <= w_cur_vec + 2'd1;
                busy    <= 1'b1;
                done    <= 1'b0;
                pass    <= 1'b0;
            end else begin
                r_state <= S_DRIVE;
                r_vec   <= w_cur_vec;
                r_dwell <= w_cur_dwell + 8'd1;
                {drv_a, drv_b} <= w_cur_vec;
                busy    <= 1'b1;
                done    <= 1'b0;
                pass    <= 1'b0;
            end
        end else if (abort && ((r_state == S_DRIVE) || start)) begin
            // Abort in a sweep, or abort colliding with start: drop to IDLE.
            // Partial fail_mask/err_count are intentionally retained.
            r_state <= S_IDLE;
            r_vec   <= 2'd0;
            r_dwell <= 8'd0;
            drv_a   <= 1'b0;
            drv_b   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            pass    <= 1'b0;
        end
    end

endmodule
`default_nettype wire
